// File: rtl/scan_mux_if.sv
// scan_mux_if: switch/select/mode inputs and LED/channel outputs of scan_mux
// Signals: i_inputs[N_CH] switches, i_select[SEL_W] manual channel, i_mode 0=manual 1=scan,
//          o_led0 selected switch, o_cur_ch[SEL_W] active channel, o_ch_step channel-change pulse
// Modports: master drives the inputs (board/bench), slave is the mux
interface scan_mux_if #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);
  logic [N_CH-1:0]  i_inputs;
  logic [SEL_W-1:0] i_select;
  logic             i_mode;
  logic             o_led0;
  logic [SEL_W-1:0] o_cur_ch;
  logic             o_ch_step;
  modport master (output i_inputs, i_select, i_mode, input o_led0, o_cur_ch, o_ch_step);
  modport slave (input i_inputs, i_select, i_mode, output o_led0, o_cur_ch, o_ch_step);
endinterface

// File: rtl/scan_mux.sv
// scan_mux: N:1 switch-to-LED selector with synchronisers, manual select or round-robin scan
// Ports: clk, rst (sync active-high), bus (scan_mux_if.slave: i_inputs/i_select/i_mode in,
//        o_led0/o_cur_ch/o_ch_step out)
// Option: define SCAN_MUX_DEBOUNCE_EN to debounce synced inputs and select over DB_CYCLES cycles
module scan_mux #(
  parameter int N_CH        = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DWELL       = 100000000,
  parameter int DB_CYCLES   = 4
) (
  input logic clk,
  input logic rst,
  scan_mux_if.slave bus
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam int DB_N  = N_CH + SEL_W;
  if (N_CH < 2 || N_CH > 32 || (1 << SEL_W) < N_CH || SYNC_STAGES < 2 || DWELL < 1 || DB_CYCLES < 1) begin : g_bad
    $error("scan_mux: parameter out of range");
  end
  logic [SYNC_STAGES-1:0][N_CH-1:0]  r_in_sync;
  logic [SYNC_STAGES-1:0][SEL_W-1:0] r_sel_sync;
  logic [SYNC_STAGES-1:0]            r_mode_sync;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_sync   <= '0;
      r_sel_sync  <= '0;
      r_mode_sync <= '0;
    end else begin
      r_in_sync   <= {r_in_sync[SYNC_STAGES-2:0], bus.i_inputs};
      r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], bus.i_select};
      r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], bus.i_mode};
    end
  end
  logic [DB_N-1:0]  w_raw, w_clean;
  logic [N_CH-1:0]  w_in;
  logic [SEL_W-1:0] w_sel;
  logic             w_mode;
  assign w_raw  = {r_sel_sync[SYNC_STAGES-1], r_in_sync[SYNC_STAGES-1]};
  assign w_mode = r_mode_sync[SYNC_STAGES-1];
`ifdef SCAN_MUX_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  logic [DB_N-1:0]            r_db;
  logic [DB_N-1:0][DB_W-1:0]  r_db_cnt;
  // A bit commits only after DB_CYCLES consecutive cycles differing from the debounced value;
  // returning to the debounced value restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db     <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < DB_N; i++) begin
        if (w_raw[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          r_db[i]     <= w_raw[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end
  assign w_clean = r_db;
`else
  assign w_clean = w_raw;
`endif
  assign w_in  = w_clean[N_CH-1:0];
  assign w_sel = w_clean[DB_N-1:N_CH];
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_cur, w_next;
  logic             r_led, r_step, w_wrap, w_sel_ok;
  // Counter sits at 0 while manual, so entering scan restarts a full dwell on the current channel.
  assign w_wrap   = r_cnt == CNT_W'(DWELL - 1);
  assign w_sel_ok = 32'(w_sel) < 32'(N_CH);
  assign w_next   = w_mode ? (w_wrap ? (r_cur == SEL_W'(N_CH - 1) ? '0 : r_cur + SEL_W'(1)) : r_cur)
                           : (w_sel_ok ? w_sel : r_cur);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_cur  <= '0;
      r_step <= 1'b0;
      r_led  <= 1'b0;
    end else begin
      r_cnt  <= (!w_mode || w_wrap) ? '0 : r_cnt + CNT_W'(1);
      r_cur  <= w_next;
      r_step <= w_next != r_cur;
      r_led  <= w_in[r_cur];
    end
  end
  assign bus.o_led0    = r_led;
  assign bus.o_cur_ch  = r_cur;
  assign bus.o_ch_step = r_step;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed self-checking bench for scan_mux (N_CH=4, SEL_W=2, SYNC_STAGES=2, DWELL=8)
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   last = 0;
  always #5 clk = ~clk;
  scan_mux_if #(.N_CH(4), .SEL_W(2)) bus ();
  scan_mux #(.N_CH(4), .SEL_W(2), .SYNC_STAGES(2), .DWELL(8), .DB_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // One cycle of scan observation: e is the channel expected after this edge,
  // led0 lags cur_ch by one cycle and only channel 2 is lit.
  task automatic adv(input int e, input string tag);
    step(1);
    check({tag, "_cur"}, int'(bus.o_cur_ch), e);
    check({tag, "_step"}, int'(bus.o_ch_step), int'(e != last));
    check({tag, "_led"}, int'(bus.o_led0), int'(last == 2));
    last = e;
  endtask
  initial begin
    int steps, at;
    bus.i_inputs = 4'b1111;
    bus.i_select = 2'd0;
    bus.i_mode   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_led", int'(bus.o_led0), 0);
      check("rst_cur", int'(bus.o_cur_ch), 0);
      check("rst_step", int'(bus.o_ch_step), 0);
    end
    rst = 1'b0;
`ifdef SCAN_MUX_DEBOUNCE_EN
    bus.i_inputs = 4'b0000;
    step(10);
    bus.i_inputs = 4'b0001;
    step(2);
    bus.i_inputs = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("db_glitch", int'(bus.o_led0), 0);
    end
    bus.i_inputs = 4'b0001;
    step(6);
    check("db_early", int'(bus.o_led0), 0);
    step(1);
    check("db_led", int'(bus.o_led0), 1);
`else
    step(2);
    check("rel_led_early", int'(bus.o_led0), 0);
    step(1);
    check("rel_led", int'(bus.o_led0), 1);
    for (int k = 0; k < 4; k++) begin
      bus.i_select = 2'(k);
      bus.i_inputs = 4'(1 << k);
      steps = 0;
      at = 0;
      for (int c = 1; c <= 10; c++) begin
        step(1);
        if (bus.o_ch_step) begin
          steps++;
          at = c;
        end
      end
      check($sformatf("man%0d_steps", k), steps, k == 0 ? 0 : 1);
      check($sformatf("man%0d_at", k), at, k == 0 ? 0 : 3);
      check($sformatf("man%0d_cur", k), int'(bus.o_cur_ch), k);
      check($sformatf("man%0d_led", k), int'(bus.o_led0), 1);
    end
    bus.i_inputs = 4'b0000;
    step(2);
    check("off_led_early", int'(bus.o_led0), 1);
    step(1);
    check("off_led", int'(bus.o_led0), 0);
    bus.i_select = 2'd0;
    step(4);
    check("home_cur", int'(bus.o_cur_ch), 0);
    bus.i_mode   = 1'b1;
    bus.i_inputs = 4'b0100;
    last = 0;
    for (int c = 1; c <= 49; c++) begin
      adv(c < 10 ? 0 : ((c - 10) / 8 + 1) % 4, "scan");
      if (c == 47) begin
        bus.i_mode   = 1'b0;
        bus.i_select = 2'd3;
      end
    end
    for (int c = 50; c <= 55; c++) adv(3, "man");
    bus.i_mode = 1'b1;
    for (int c = 56; c <= 66; c++) adv(c < 65 ? 3 : 0, "rescan");
    for (int c = 67; c <= 90; c++) adv(((c - 65) / 8) % 4, "scan2");
    rst = 1'b1;
    step(1);
    check("mid_rst_cur", int'(bus.o_cur_ch), 0);
    check("mid_rst_led", int'(bus.o_led0), 0);
    check("mid_rst_step", int'(bus.o_ch_step), 0);
    rst = 1'b0;
    last = 0;
    for (int c = 92; c <= 102; c++) adv(c < 101 ? 0 : 1, "post_rst");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised N:1 switch-to-LED selector. Successor to the fixed 4:1 combinational switch mux.
- Adds input synchronisation and a registered output. Channel selection is either manual (select switches) or automatic (round-robin scan with a programmable dwell time).
- Sits between board switches and a single status LED. Also exports the active channel index for a 7-segment or debug display.

Parameters:
- N_CH, 4, number of input channels (2..32).
- SEL_W, 2, width of select and cur_ch; must satisfy 2^SEL_W >= N_CH.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (minimum 2).
- DWELL, 100000000, clock cycles spent on each channel in scan mode (minimum 1).
- DB_CYCLES, 4, debounce stable-count length; used only when DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- inputs  in  N_CH  asynchronous switch inputs.
- select  in  SEL_W  asynchronous manual channel select.
- mode  in  1  asynchronous mode switch: 0 = manual, 1 = auto-scan.
- led0  out  1  registered value of the active channel.
- cur_ch  out  SEL_W  registered active channel index.
- ch_step  out  1  one-cycle pulse in the cycle cur_ch takes a new value.

Behaviour:
- Clocking and reset: single clock domain, sync active-high rst. On rst, all synchroniser flops, cur_ch, led0, ch_step and the dwell counter are 0; mode is treated as manual.
- Synchronisers: inputs, select and mode each pass through SYNC_STAGES flops. All internal logic uses the synced values only (s_in, s_sel, s_mode).
- Manual mode (s_mode = 0):
  - cur_ch <= s_sel each cycle.
  - If s_sel >= N_CH, cur_ch holds its previous value; no step pulse.
- Auto-scan mode (s_mode = 1):
  - Dwell counter runs 0..DWELL-1.
  - At DWELL-1: counter -> 0 and cur_ch -> cur_ch+1, wrapping N_CH-1 -> 0. select is ignored.
- Mode transitions:
  - Manual->auto (s_mode rising): counter cleared to 0 in that cycle; scan starts from the current cur_ch. The first advance happens DWELL cycles later.
  - Auto->manual: counter cleared and held at 0; cur_ch follows s_sel from the next cycle.
- Output: led0 <= s_in[cur_ch], registered using the current cur_ch.
- Latencies:
  - inputs change -> led0: SYNC_STAGES+1 cycles.
  - select change -> cur_ch: SYNC_STAGES+1 cycles.
  - select change -> led0: SYNC_STAGES+2 cycles.
- ch_step:
  - High for exactly one cycle whenever the registered cur_ch differs from its prior value, in both modes. Coincident with the new cur_ch.
  - Never asserted during or in the cycle after rst.
- Reset mid-scan: returns to channel 0 with counter 0. After reset, the scan restarts only once s_mode is re-synced high, i.e. SYNC_STAGES cycles after release.
- DWELL = 1: cur_ch advances every cycle; ch_step is held high continuously while scanning.

Optional Feature:
- Macro: SCAN_MUX_DEBOUNCE_EN.
- Defined:
  - Each synced bit of inputs and select passes through a debouncer before use.
  - The debounced value updates only after the raw synced bit has been stable and differs from the debounced value for DB_CYCLES consecutive cycles.
  - A counter restarts on any toggle.
  - Debounced value resets to 0.
  - Adds DB_CYCLES cycles to the input and select latencies above.
  - mode is not debounced.
- Not defined: no debounce logic is built; DB_CYCLES is unused; latencies are exactly as stated under Behaviour.

Test Plan (N_CH=4, SEL_W=2, SYNC_STAGES=2, DWELL=8, macro off unless stated):
- Reset release: hold rst 3 cycles with inputs=4'b1111 -> during reset led0=0, cur_ch=0, ch_step=0. First led0=1 appears 3 cycles after release.
- Manual walk: mode=0; for k=0..3 set select=k, inputs=1<<k, hold 10 cycles -> cur_ch=k and led0=1 each step. ch_step pulses once per select change at SYNC_STAGES+1 cycles. Then inputs=0 -> led0=0 after 3 cycles.
- Auto scan wrap: mode=1, inputs=4'b0100 -> cur_ch sequence 0,1,2,3,0 with exactly 8 cycles per channel. led0=1 only while cur_ch=2, lagging by 1 cycle. One ch_step per advance, including 3->0.
- Mode switch mid-dwell: in scan at cur_ch=1, counter=5, set mode=0 with select=3 -> no further scan advance; cur_ch=3 after synchroniser delay. Set mode=1 -> next advance occurs exactly 8 cycles after s_mode rises.
- Reset mid-scan: assert rst for 1 cycle while cur_ch=3 -> cur_ch=0, led0=0, counter restarts. First advance occurs 8 cycles after s_mode re-syncs high.
- Debounce (SCAN_MUX_DEBOUNCE_EN, DB_CYCLES=4): pulse inputs[0] high for 2 cycles with select=0 -> led0 stays 0. Hold it high for 6 cycles -> led0=1 after 2+4+1 cycles.
